// File: rtl/mem_access_unit.sv
// Memory-access stage controller: turns an ALU address plus LDUR/STUR controls into a bus request/grant/response sequence.
// Latency: store 2 cycles and load 3 cycles with an immediate bus; error ops 1 cycle; stall holds upstream until DONE.
module mem_access_unit #(
    parameter int N       = 64,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         MemRead,
    input  logic         MemWrite,
    input  logic [N-1:0] alu_result,
    input  logic [N-1:0] writeData,
    output logic         stall,
    output logic         done,
    output logic [N-1:0] readData,
    output logic         misaligned,
    output logic         illegal,
    output logic         bus_err,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_gnt,
    input  logic         mem_rvalid,
    input  logic [N-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [N-1:0]  addr_q;
    logic [N-1:0]  wdata_q;
    logic [N-1:0]  rdata_q;
    logic          we_q;
    logic [2:0]    err_q;     // {illegal, misaligned, bus_err} for the op in flight

    logic          accept;
    logic          set_ill;
    logic          set_mis;
    logic          set_bus;
    logic          load_rd;
    logic          busy;
    logic          cnt_hit;

    assign busy    = (state == REQ) || (state == WAIT);
    // A read granted on the last budget cycle enters WAIT already past the
    // limit, so the compare is >= to keep the total REQ+WAIT time bounded.
    assign cnt_hit = (cnt >= CNT_LAST);

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        accept    = 1'b0;
        set_ill   = 1'b0;
        set_mis   = 1'b0;
        set_bus   = 1'b0;
        load_rd   = 1'b0;
        case (state)
            IDLE: begin
                if (start && (MemRead || MemWrite)) begin
                    stall = 1'b1;
                    if (MemRead && MemWrite) begin
                        set_ill   = 1'b1;
                        state_nxt = DONE;
                    end else if (alu_result[2:0] != 3'b000) begin
                        set_mis   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (mem_gnt) begin
                    state_nxt = we_q ? DONE : WAIT;
                end else if (cnt_hit) begin
                    set_bus   = 1'b1;
                    state_nxt = DONE;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (mem_rvalid) begin
                    load_rd   = 1'b1;
                    state_nxt = DONE;
                end else if (cnt_hit) begin
                    set_bus   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q  <= alu_result;
                wdata_q <= writeData;
                we_q    <= MemWrite;
            end
            if (accept) begin
                cnt <= '0;
            end else if (busy && (cnt != CNT_MAX)) begin
                cnt <= cnt + CW'(1);
            end
            if (load_rd) begin
                rdata_q <= mem_rdata;
            end
            if (state == IDLE) begin
                err_q <= {set_ill, set_mis, 1'b0};
            end else if (set_bus) begin
                err_q[0] <= 1'b1;
            end
        end
    end

    // mem_req decodes straight from state so an asynchronous reset drops it at once.
    assign mem_req    = (state == REQ);
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign readData   = rdata_q;
    assign done       = (state == DONE);
    assign illegal    = done && err_q[2];
    assign misaligned = done && err_q[1];
    assign bus_err    = done && err_q[0];

    a_done_one_cycle: assert property (@(posedge clk) disable iff (reset) done |=> !done);
    a_req_stalls:     assert property (@(posedge clk) disable iff (reset) mem_req |-> stall);
    a_one_flag:       assert property (@(posedge clk) disable iff (reset)
                                       $onehot0({illegal, misaligned, bus_err}));

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random ops against a timing/result model.
module tb_mem_access_unit;

    localparam int N = 64;
    localparam int T = 16;

    logic         clk;
    logic         reset;
    logic         start;
    logic         MemRead;
    logic         MemWrite;
    logic [N-1:0] alu_result;
    logic [N-1:0] writeData;
    logic         stall;
    logic         done;
    logic [N-1:0] readData;
    logic         misaligned;
    logic         illegal;
    logic         bus_err;
    logic         mem_req;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [N-1:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    logic [N-1:0] exp_rdata = '0;
    logic [N-1:0] exp_addr  = '0;
    logic [N-1:0] exp_wdata = '0;

    mem_access_unit #(.N(N), .TIMEOUT(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .alu_result (alu_result),
        .writeData  (writeData),
        .stall      (stall),
        .done       (done),
        .readData   (readData),
        .misaligned (misaligned),
        .illegal    (illegal),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got hang, want completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // One op: start in cycle 0, grant in cycle 1+g, read data in cycle 2+g+r.
    task automatic run_op(input string tag, input logic mr, input logic mw,
                          input logic [N-1:0] addr, input logic [N-1:0] wd,
                          input logic [N-1:0] rd, input int g, input int r);
        int   exp_done;
        int   exp_req;
        bit   e_ill, e_mis, e_bus;
        int   t_rv;
        int   limit;
        int   done_cyc, done_cnt, stall_cnt, req_cnt, req_bad;
        logic g_ill, g_mis, g_bus;
        bit   rv_now;

        e_ill = 0; e_mis = 0; e_bus = 0; exp_req = 0;
        t_rv  = g + 1 + r;
        if (!mr && !mw) begin
            exp_done = -1;
        end else if (mr && mw) begin
            exp_done = 1; e_ill = 1;
        end else if (addr[2:0] != 3'b000) begin
            exp_done = 1; e_mis = 1;
        end else begin
            exp_addr  = addr;
            exp_wdata = wd;
            exp_req   = (g < T - 1 ? g : T - 1) + 1;
            if (g > T - 1) begin
                exp_done = T + 1; e_bus = 1;
            end else if (mw) begin
                exp_done = g + 2;
            end else if (t_rv <= T - 1 || t_rv == g + 1) begin
                exp_done  = t_rv + 2;
                exp_rdata = rd;
            end else begin
                exp_done = ((T - 1 > g + 1) ? T - 1 : g + 1) + 2;
                e_bus    = 1;
            end
        end

        limit = (exp_done < 0) ? 4 : exp_done + 2;
        done_cyc = -1; done_cnt = 0; stall_cnt = 0; req_cnt = 0; req_bad = 0;
        g_ill = 0; g_mis = 0; g_bus = 0;

        start      = 1'b1;
        MemRead    = mr;
        MemWrite   = mw;
        alu_result = addr;
        writeData  = wd;
        for (int c = 0; c < limit; c++) begin
            rv_now     = (mr && !mw && c == 2 + g + r);
            mem_gnt    = (c == 1 + g);
            mem_rvalid = rv_now || (c <= 1 + g && $urandom_range(0, 1) == 1);
            mem_rdata  = rv_now ? rd : {$urandom, $urandom};
            @(negedge clk);
            if (stall) stall_cnt++;
            if (mem_req) begin
                req_cnt++;
                if (mem_addr !== addr || mem_wdata !== wd || mem_we !== mw) req_bad++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    g_ill = illegal; g_mis = misaligned; g_bus = bus_err;
                end
            end
            @(posedge clk);
            #1;
            start      = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            alu_result = {$urandom, $urandom};
            writeData  = {$urandom, $urandom};
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;

        check_val({tag, ".done_cycle"}, N'(done_cyc), N'(exp_done));
        check_val({tag, ".done_pulses"}, N'(done_cnt), N'(exp_done >= 0 ? 1 : 0));
        check_val({tag, ".illegal"}, N'(g_ill), N'(e_ill));
        check_val({tag, ".misaligned"}, N'(g_mis), N'(e_mis));
        check_val({tag, ".bus_err"}, N'(g_bus), N'(e_bus));
        check_val({tag, ".stall_cycles"}, N'(stall_cnt), N'(exp_done >= 0 ? exp_done : 0));
        check_val({tag, ".req_cycles"}, N'(req_cnt), N'(exp_req));
        check_val({tag, ".req_payload_bad"}, N'(req_bad), '0);
        check_val({tag, ".readData"}, readData, exp_rdata);
        check_val({tag, ".mem_addr_hold"}, mem_addr, exp_addr);
        check_val({tag, ".mem_wdata_hold"}, mem_wdata, exp_wdata);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, ".stall"}, N'(stall), '0);
        check_val({tag, ".done"}, N'(done), '0);
        check_val({tag, ".flags"}, N'({illegal, misaligned, bus_err}), '0);
        check_val({tag, ".mem_req"}, N'(mem_req), '0);
        check_val({tag, ".mem_we"}, N'(mem_we), '0);
        check_val({tag, ".mem_addr"}, mem_addr, '0);
        check_val({tag, ".mem_wdata"}, mem_wdata, '0);
        check_val({tag, ".readData"}, readData, '0);
    endtask

    initial begin
        int           kind;
        logic         mr, mw;
        logic [N-1:0] a;

        reset = 1'b1; start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        alu_result = '0; writeData = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        run_op("store", 1'b0, 1'b1, 64'h10, 64'hDEAD_BEEF, '0, 0, 0);
        run_op("load", 1'b1, 1'b0, 64'h18, 64'h5, 64'h0123_4567_89AB_CDEF, 3, 2);
        run_op("store_after_load", 1'b0, 1'b1, 64'h20, 64'h77, '0, 1, 0);
        run_op("misaligned", 1'b1, 1'b0, 64'h1C, 64'h1, '0, 0, 0);
        run_op("illegal", 1'b1, 1'b1, 64'h1C, 64'h2, '0, 0, 0);
        run_op("noop", 1'b0, 1'b0, 64'h40, 64'h3, '0, 0, 0);
        run_op("timeout", 1'b0, 1'b1, 64'h30, 64'h4, '0, 100, 0);
        run_op("late_gnt", 1'b0, 1'b1, 64'h38, 64'h6, '0, T - 1, 0);
        run_op("load_timeout", 1'b1, 1'b0, 64'h48, 64'h7, 64'hBAD, 2, 50);

        // Abort a load while it is waiting for read data.
        start = 1'b1; MemRead = 1'b1; MemWrite = 1'b0;
        alu_result = 64'h50; writeData = 64'h99;
        @(posedge clk); #1;
        start = 1'b0; MemRead = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        exp_rdata = '0; exp_addr = '0; exp_wdata = '0;
        check_all_zero("reset_in_wait");
        @(posedge clk); #1;
        reset = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        check_val("stray_rvalid.done", N'(done), '0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check_val("stray_rvalid.readData", readData, '0);
        @(posedge clk); #1;
        run_op("load_after_reset", 1'b1, 1'b0, 64'h60, 64'h8, 64'hCAFE_F00D_1234_5678, 0, 0);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            a    = {$urandom, $urandom} & ~64'h7;
            mr   = $urandom_range(0, 1) == 1;
            mw   = !mr;
            if (kind == 0) begin
                mr = 1'b0; mw = 1'b0;
            end else if (kind == 1) begin
                mr = 1'b1; mw = 1'b1;
            end else if (kind == 2) begin
                a = a | 64'($urandom_range(1, 7));
            end
            run_op($sformatf("rand%0d", i), mr, mw, a, {$urandom, $urandom},
                   {$urandom, $urandom}, $urandom_range(0, T + 2), $urandom_range(0, T));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
